// File: rtl/mem_queue_reader_pkg.sv
// Shared definitions for the circular task-queue reader and its producer-side peer.
package mem_queue_reader_pkg;

    // Default queue geometry; ptr_t is shared with the producer writer.
    localparam int unsigned QUEUE_SIZE = 16;
    localparam int unsigned AW         = $clog2(QUEUE_SIZE);

    // Slot index plus one wrap bit in the MSB.
    typedef logic [AW:0] ptr_t;

    // Pointer width for an arbitrary power-of-two queue depth.
    function automatic int unsigned ptr_width(input int unsigned size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/mem_queue_skid2.sv
// Two-entry output FIFO: absorbs the one-cycle memory latency so the stream
// can run at one beat per cycle under backpressure. Head register drives the output.
module mem_queue_skid2 #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_occ;
    logic             w_pop;

    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_head;
    assign o_occ   = r_occ;
    assign w_pop   = o_valid && i_ready;

    // Head/tail shuffle on push, pop or both; order is always head first.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= i_data;
                    else               r_tail <= i_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; with two entries the tail moves up.
                    if (r_occ == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else begin
                        r_head <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_occ_range: assert property (@(posedge i_clk) disable iff (!i_rstn) r_occ <= 2'd2);
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(i_push && !w_pop && (r_occ == 2'd2)));
`endif

endmodule

// File: rtl/mem_queue_reader.sv
// Consumer side of a circular queue in dual-port RAM: issues in-order slot reads
// (clearing each slot read-first in the same cycle) and streams them out.
module mem_queue_reader
    import mem_queue_reader_pkg::*;
#(
    parameter int unsigned      SIZE          = 16,
    parameter int unsigned      WIDTH         = 128,
    parameter bit               CLEAR_ON_READ = 1'b1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE   = '0,
    localparam int unsigned     PW            = ptr_width(SIZE)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [PW-1:0]    i_wr_ptr,
    output logic [PW-1:0]    o_rd_ptr,
    output logic             o_mem_en,
    output logic             o_mem_we,
    output logic [PW-2:0]    o_mem_addr,
    output logic [WIDTH-1:0] o_mem_din,
    input  logic [WIDTH-1:0] i_mem_dout,
    output logic             o_m_tvalid,
    input  logic             i_m_tready,
    output logic [WIDTH-1:0] o_m_tdata
);

    logic [PW-1:0] r_rd_ptr;
    logic          r_inflight;
    logic          w_empty;
    logic          w_pop;
    logic          w_issue;
    logic [1:0]    w_occ;
    logic [2:0]    w_load;

    assign w_empty = (r_rd_ptr == i_wr_ptr);
    assign w_pop   = o_m_tvalid && i_m_tready;
    assign w_load  = {1'b0, w_occ} + {2'b00, r_inflight};
    // Reserve a buffer entry for every read in flight; a pop this cycle frees one.
    // Gated by reset so the memory port is quiet while reset is held.
    assign w_issue = i_rstn && !w_empty && (w_load < (3'd2 + {2'b00, w_pop}));

    assign o_mem_en   = w_issue;
    assign o_mem_we   = w_issue && CLEAR_ON_READ;
    assign o_mem_addr = r_rd_ptr[PW-2:0];
    assign o_mem_din  = CLEAR_VALUE;
    assign o_rd_ptr   = r_rd_ptr;

    // Read pointer counts issued slots; in-flight flag marks data arriving next cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_rd_ptr   <= r_rd_ptr + PW'(w_issue);
            r_inflight <= w_issue;
        end
    end

    mem_queue_skid2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (r_inflight),
        .i_data  (i_mem_dout),
        .o_valid (o_m_tvalid),
        .i_ready (i_m_tready),
        .o_data  (o_m_tdata),
        .o_occ   (w_occ)
    );

`ifndef SYNTHESIS
    logic [PW-1:0] w_dist;
    assign w_dist = i_wr_ptr - r_rd_ptr;

    a_ptr_dist: assert property (@(posedge i_clk) disable iff (!i_rstn) w_dist <= PW'(SIZE));
    a_occ: assert property (@(posedge i_clk) disable iff (!i_rstn) w_load <= 3'd2);
    a_stall_stable: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (o_m_tvalid && !i_m_tready) |=> (o_m_tvalid && $stable(o_m_tdata)));
`endif

endmodule

// File: tb/tb_mem_queue_reader.sv
// Bench for mem_queue_reader: RAM model behind the DUT port, queue-based
// reference of the expected stream, directed steps plus a randomized phase.
module tb_mem_queue_reader;

    localparam int unsigned SIZE  = 16;
    localparam int unsigned WIDTH = 128;
    localparam int unsigned AW    = 4;

    typedef logic [WIDTH-1:0] data_t;
    typedef logic [AW:0]      qptr_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Clearing instance.
    qptr_t         wr_ptr, rd_ptr;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    data_t         mem_din, mem_dout, tdata;
    logic          tvalid, tready;
    logic          prod_we;
    logic [AW-1:0] prod_addr;
    data_t         prod_data;
    data_t         mem [SIZE];

    // Non-clearing instance.
    qptr_t         nc_wr_ptr, nc_rd_ptr;
    logic          nc_mem_en, nc_mem_we;
    logic [AW-1:0] nc_mem_addr;
    data_t         nc_mem_din, nc_mem_dout, nc_tdata;
    logic          nc_tvalid;
    logic          nc_prod_we;
    logic [AW-1:0] nc_prod_addr;
    data_t         nc_prod_data;
    data_t         nc_mem [SIZE];
    logic          nc_we_seen = 1'b0;

    mem_queue_reader #(.SIZE(SIZE), .WIDTH(WIDTH), .CLEAR_ON_READ(1'b1)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_wr_ptr(wr_ptr), .o_rd_ptr(rd_ptr),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
        .i_mem_dout(mem_dout), .o_m_tvalid(tvalid), .i_m_tready(tready), .o_m_tdata(tdata)
    );

    mem_queue_reader #(.SIZE(SIZE), .WIDTH(WIDTH), .CLEAR_ON_READ(1'b0)) dut_nc (
        .i_clk(clk), .i_rstn(rstn), .i_wr_ptr(nc_wr_ptr), .o_rd_ptr(nc_rd_ptr),
        .o_mem_en(nc_mem_en), .o_mem_we(nc_mem_we), .o_mem_addr(nc_mem_addr),
        .o_mem_din(nc_mem_din), .i_mem_dout(nc_mem_dout), .o_m_tvalid(nc_tvalid),
        .i_m_tready(1'b1), .o_m_tdata(nc_tdata)
    );

    // Dual-port READ_FIRST RAMs: producer port and DUT port.
    always @(posedge clk) begin
        if (prod_we) mem[prod_addr] <= prod_data;
        if (mem_en) begin
            mem_dout <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_din;
        end
        if (nc_prod_we) nc_mem[nc_prod_addr] <= nc_prod_data;
        if (nc_mem_en) begin
            nc_mem_dout <= nc_mem[nc_mem_addr];
            if (nc_mem_we) nc_mem[nc_mem_addr] <= nc_mem_din;
        end
        if (nc_mem_we) nc_we_seen <= 1'b1;
    end

    // Reference model state.
    int            checks = 0;
    int            failures = 0;
    data_t         exp_q[$];
    logic [AW-1:0] addr_log[$];
    qptr_t         m_rd;
    int            issued, delivered, beats, produced, cyc_no, first_beat, last_beat, start_cyc;
    logic          prev_stall;
    data_t         prev_data;
    data_t         vals[16];

    function automatic data_t rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input data_t obs, input data_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called at the negedge with inputs set; checks run before the posedge.
    task automatic cyc();
        #1;
        check("rd_ptr", data_t'(rd_ptr), data_t'(m_rd));
        if (prev_stall) begin
            check("stall_valid", data_t'(tvalid), data_t'(1));
            check("stall_data", tdata, prev_data);
        end
        if (m_rd == wr_ptr) check("idle_en", data_t'(mem_en), data_t'(0));
        if (mem_en) begin
            check("issue_addr", data_t'(mem_addr), data_t'(m_rd[AW-1:0]));
            check("issue_we", data_t'(mem_we), data_t'(1));
            check("issue_din", mem_din, data_t'(0));
            addr_log.push_back(mem_addr);
            m_rd = m_rd + 1'b1;
            issued++;
        end
        if (tvalid && tready) begin
            if (exp_q.size() == 0) check("spurious_beat", data_t'(tvalid), data_t'(0));
            else                   check("beat_data", tdata, exp_q.pop_front());
            delivered++;
            beats++;
            if (first_beat < 0) first_beat = cyc_no;
            last_beat = cyc_no;
        end
        check("outstanding_le2", data_t'(issued - delivered <= 2), data_t'(1));
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rd = '0;
        issued = 0;
        delivered = 0;
        prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        wr_ptr = '0;
        model_reset();
        cyc();
        rstn = 1'b1;
        cyc();
    endtask

    task automatic write_slot(input logic [AW-1:0] idx, input data_t d);
        prod_we = 1'b1;
        prod_addr = idx;
        prod_data = d;
        cyc();
        prod_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic  pend;
        data_t pend_data;
        qptr_t diff;
        wr_ptr = '0; tready = 1'b0; prod_we = 1'b0; prod_addr = '0; prod_data = '0;
        nc_wr_ptr = '0; nc_prod_we = 1'b0; nc_prod_addr = '0; nc_prod_data = '0;
        model_reset();
        cyc_no = 0; beats = 0; first_beat = -1; last_beat = 0; produced = 0;
        prev_data = '0;
        @(negedge clk);
        cyc();
        cyc();
        check("rst_rd_ptr", data_t'(rd_ptr), data_t'(0));
        check("rst_tvalid", data_t'(tvalid), data_t'(0));
        check("rst_tdata", tdata, data_t'(0));
        check("rst_mem_en", data_t'(mem_en), data_t'(0));
        check("rst_mem_we", data_t'(mem_we), data_t'(0));
        check("rst_mem_addr", data_t'(mem_addr), data_t'(0));
        rstn = 1'b1;
        cyc();

        // Single slot.
        write_slot(4'd0, data_t'(8'hA5));
        tready = 1'b1;
        wr_ptr = 5'd1;
        exp_q.push_back(data_t'(8'hA5));
        #1;
        check("ss_mem_en", data_t'(mem_en), data_t'(1));
        check("ss_mem_we", data_t'(mem_we), data_t'(1));
        check("ss_mem_addr", data_t'(mem_addr), data_t'(0));
        cyc();
        check("ss_valid_t1", data_t'(tvalid), data_t'(0));
        cyc();
        check("ss_valid_t2", data_t'(tvalid), data_t'(1));
        check("ss_data_t2", tdata, data_t'(8'hA5));
        cyc();
        check("ss_valid_t3", data_t'(tvalid), data_t'(0));
        check("ss_cleared", mem[0], data_t'(0));
        check("ss_rd_ptr", data_t'(rd_ptr), data_t'(1));

        // Burst of 16 from a fresh reset.
        do_reset();
        for (int i = 0; i < 16; i++) write_slot(4'(i), data_t'(32'h100 + i));
        wr_ptr = 5'd16;
        for (int i = 0; i < 16; i++) exp_q.push_back(data_t'(32'h100 + i));
        tready = 1'b1;
        beats = 0; first_beat = -1; start_cyc = cyc_no;
        for (int c = 0; c < 40 && beats < 16; c++) cyc();
        check("burst_beats", data_t'(beats), data_t'(16));
        check("burst_latency", data_t'(first_beat - start_cyc), data_t'(2));
        check("burst_no_gaps", data_t'(last_beat - first_beat), data_t'(15));
        check("burst_rd_ptr", data_t'(rd_ptr), data_t'(16));

        // Backpressure: 8 pending, ready low 5 cycles then toggling.
        tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vals[i] = rnd();
            write_slot(4'(i), vals[i]);
        end
        wr_ptr = 5'd24;
        for (int i = 0; i < 8; i++) exp_q.push_back(vals[i]);
        beats = 0;
        repeat (5) cyc();
        check("bp_outstanding", data_t'(issued - delivered), data_t'(2));
        check("bp_head_valid", data_t'(tvalid), data_t'(1));
        check("bp_head_data", tdata, vals[0]);
        for (int c = 0; c < 60 && beats < 8; c++) begin
            tready = ~tready;
            cyc();
        end
        check("bp_beats", data_t'(beats), data_t'(8));
        check("bp_rd_ptr", data_t'(rd_ptr), data_t'(24));
        check("bp_drained", data_t'(tvalid), data_t'(0));

        // Wrap-around from index 14.
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            vals[i] = rnd();
            write_slot(4'(i), vals[i]);
        end
        wr_ptr = 5'd14;
        for (int i = 0; i < 14; i++) exp_q.push_back(vals[i]);
        beats = 0;
        for (int c = 0; c < 40 && beats < 14; c++) cyc();
        check("wrap_pre_rd_ptr", data_t'(rd_ptr), data_t'(14));
        addr_log.delete();
        for (int i = 0; i < 4; i++) begin
            vals[i] = rnd();
            write_slot(4'((14 + i) % 16), vals[i]);
        end
        wr_ptr = 5'd18;
        for (int i = 0; i < 4; i++) exp_q.push_back(vals[i]);
        beats = 0;
        for (int c = 0; c < 20 && beats < 4; c++) cyc();
        check("wrap_issue_count", data_t'(addr_log.size()), data_t'(4));
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            check("wrap_addr", data_t'(addr_log[i]), data_t'((14 + i) % 16));
        check("wrap_rd_ptr", data_t'(rd_ptr), data_t'(18));
        check("wrap_beats", data_t'(beats), data_t'(4));

        // Randomized producer and ready.
        pend = 1'b0; pend_data = '0; beats = 0; produced = 0;
        for (int c = 0; c < 300; c++) begin
            if (pend) begin
                wr_ptr = wr_ptr + 1'b1;
                exp_q.push_back(pend_data);
                produced++;
                pend = 1'b0;
            end
            diff = wr_ptr - rd_ptr;
            if ((diff < qptr_t'(SIZE)) && ($urandom_range(3) != 0)) begin
                pend_data = rnd();
                prod_addr = wr_ptr[AW-1:0];
                prod_data = pend_data;
                prod_we = 1'b1;
                pend = 1'b1;
            end else begin
                prod_we = 1'b0;
            end
            tready = ($urandom_range(2) != 0);
            cyc();
        end
        prod_we = 1'b0;
        if (pend) begin
            wr_ptr = wr_ptr + 1'b1;
            exp_q.push_back(pend_data);
            produced++;
        end
        tready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) cyc();
        check("rand_beats", data_t'(beats), data_t'(produced));
        check("rand_rd_ptr", data_t'(rd_ptr), data_t'(wr_ptr));
        check("rand_idle", data_t'(tvalid), data_t'(0));

        // Reset mid-burst with the buffer full.
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vals[i] = rnd();
            write_slot(4'(i), vals[i]);
        end
        wr_ptr = 5'd8;
        for (int i = 0; i < 8; i++) exp_q.push_back(vals[i]);
        repeat (4) cyc();
        check("mid_full_valid", data_t'(tvalid), data_t'(1));
        rstn = 1'b0;
        #1;
        check("mid_rst_tvalid", data_t'(tvalid), data_t'(0));
        check("mid_rst_rd_ptr", data_t'(rd_ptr), data_t'(0));
        check("mid_rst_mem_en", data_t'(mem_en), data_t'(0));
        check("mid_rst_mem_we", data_t'(mem_we), data_t'(0));
        check("mid_rst_tdata", tdata, data_t'(0));
        wr_ptr = '0;
        model_reset();
        cyc();
        rstn = 1'b1;
        vals[0] = rnd();
        write_slot(4'd0, vals[0]);
        tready = 1'b1;
        wr_ptr = 5'd1;
        exp_q.push_back(vals[0]);
        #1;
        check("post_rst_issue", data_t'(mem_en), data_t'(1));
        cyc();
        cyc();
        check("post_rst_valid", data_t'(tvalid), data_t'(1));
        check("post_rst_data", tdata, vals[0]);
        cyc();
        check("post_rst_rd_ptr", data_t'(rd_ptr), data_t'(1));

        // No clear on read.
        nc_prod_we = 1'b1; nc_prod_addr = 4'd0; nc_prod_data = data_t'(8'hA5);
        cyc();
        nc_prod_we = 1'b0;
        nc_wr_ptr = 5'd1;
        #1;
        check("nc_mem_en", data_t'(nc_mem_en), data_t'(1));
        check("nc_mem_we", data_t'(nc_mem_we), data_t'(0));
        check("nc_mem_addr", data_t'(nc_mem_addr), data_t'(0));
        cyc();
        check("nc_valid_t1", data_t'(nc_tvalid), data_t'(0));
        cyc();
        check("nc_valid_t2", data_t'(nc_tvalid), data_t'(1));
        check("nc_data_t2", nc_tdata, data_t'(8'hA5));
        cyc();
        check("nc_valid_t3", data_t'(nc_tvalid), data_t'(0));
        check("nc_mem_kept", nc_mem[0], data_t'(8'hA5));
        check("nc_rd_ptr", data_t'(nc_rd_ptr), data_t'(1));
        check("nc_we_never", data_t'(nc_we_seen), data_t'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
